// File: rtl/turbo_deframer.sv
// rtl/turbo_deframer.sv - receive-side deframer for the turbo encoder serial output stream
//
// Purpose: delimits each code block (K data cycles + TAIL_LEN termination
// cycles), packs the xk/zk/zkp streams MSB-first into byte lanes, captures
// the 12 tail bits and reports premature look_now drops as framing errors.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   look_now                   stream valid, contiguous over a whole block
//   length_in                  block length flag, sampled on bit 0 of a block
//   xk, zk, zkp                systematic / parity-1 / parity-2 bits (tail bits in TAIL)
//   sys_byte, par1_byte,
//   par2_byte                  packed byte lanes, held between strobes
//   byte_valid, sop, eop       byte strobe, first byte / last data byte markers
//   tail_bits, blk_len,
//   blk_done                   termination bits and length flag, strobe on completion
//   frame_err, err_cnt         framing error strobe and saturating error count
module turbo_deframer #(
   parameter int K_SHORT  = 1056,
   parameter int K_LONG   = 6144,
   parameter int TAIL_LEN = 4,
   parameter int CNT_W    = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        look_now,
   input  logic        length_in,
   input  logic        xk,
   input  logic        zk,
   input  logic        zkp,
   output logic [7:0]  sys_byte,
   output logic [7:0]  par1_byte,
   output logic [7:0]  par2_byte,
   output logic        byte_valid,
   output logic        sop,
   output logic        eop,
   output logic [11:0] tail_bits,
   output logic        blk_done,
   output logic        blk_len,
   output logic        frame_err,
   output logic [7:0]  err_cnt
);

   localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_t;

   state_t state, state_next;

   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] k_last;
   logic [TW-1:0]    tail_cnt;
   // Only 7 bits are buffered; the 8th bit goes straight into the output byte.
   logic [6:0]       sys_sr, par1_sr, par2_sr;
   // Holds the first three tail triplets; the fourth is appended on capture.
   logic [8:0]       tail_sr;
   logic             len_lat;
   logic             first_flag;

   logic             byte_done;
   logic             last_bit;
   logic             tail_last;
   logic             err_now;

   assign k_last = len_lat ? CNT_W'(K_LONG - 1) : CNT_W'(K_SHORT - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      byte_done  = 1'b0;
      last_bit   = 1'b0;
      tail_last  = 1'b0;
      err_now    = 1'b0;
      case (state)
         IDLE: begin
            if (look_now) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (!look_now) begin
               err_now    = 1'b1;
               state_next = IDLE;
            end else begin
               byte_done = (bit_cnt[2:0] == 3'd7);
               if (bit_cnt == k_last) begin
                  last_bit   = 1'b1;
                  state_next = TAIL;
               end
            end
         end
         TAIL: begin
            if (!look_now) begin
               err_now    = 1'b1;
               state_next = IDLE;
            end else if (tail_cnt == TW'(TAIL_LEN - 1)) begin
               tail_last  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt    <= '0;
         tail_cnt   <= '0;
         sys_sr     <= '0;
         par1_sr    <= '0;
         par2_sr    <= '0;
         tail_sr    <= '0;
         len_lat    <= 1'b0;
         first_flag <= 1'b0;
         sys_byte   <= '0;
         par1_byte  <= '0;
         par2_byte  <= '0;
         byte_valid <= 1'b0;
         sop        <= 1'b0;
         eop        <= 1'b0;
         tail_bits  <= '0;
         blk_done   <= 1'b0;
         blk_len    <= 1'b0;
         frame_err  <= 1'b0;
         err_cnt    <= '0;
      end else begin
         byte_valid <= 1'b0;
         sop        <= 1'b0;
         eop        <= 1'b0;
         blk_done   <= 1'b0;
         frame_err  <= 1'b0;

         if (err_now) begin
            // Partial byte and tail are abandoned; emitted bytes stand.
            bit_cnt   <= '0;
            tail_cnt  <= '0;
            frame_err <= 1'b1;
            if (err_cnt != 8'hFF) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (look_now) begin
                     len_lat    <= length_in;
                     first_flag <= 1'b1;
                     bit_cnt    <= CNT_W'(1);
                     tail_cnt   <= '0;
                     sys_sr     <= {6'd0, xk};
                     par1_sr    <= {6'd0, zk};
                     par2_sr    <= {6'd0, zkp};
                  end
               end
               DATA: begin
                  sys_sr  <= {sys_sr[5:0], xk};
                  par1_sr <= {par1_sr[5:0], zk};
                  par2_sr <= {par2_sr[5:0], zkp};
                  bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
                  if (byte_done) begin
                     sys_byte   <= {sys_sr, xk};
                     par1_byte  <= {par1_sr, zk};
                     par2_byte  <= {par2_sr, zkp};
                     byte_valid <= 1'b1;
                     sop        <= first_flag;
                     eop        <= last_bit;
                     first_flag <= 1'b0;
                  end
               end
               TAIL: begin
                  tail_sr  <= {tail_sr[5:0], xk, zk, zkp};
                  tail_cnt <= tail_cnt + TW'(1);
                  if (tail_last) begin
                     tail_bits <= {tail_sr, xk, zk, zkp};
                     blk_done  <= 1'b1;
                     blk_len   <= len_lat;
                     tail_cnt  <= '0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_turbo_deframer.sv
// tb/tb_turbo_deframer.sv - scoreboard bench for turbo_deframer
module tb_turbo_deframer;

   logic        clk = 1'b0;
   logic        rst;
   logic        look_now;
   logic        length_in;
   logic        xk, zk, zkp;
   logic [7:0]  sys_byte, par1_byte, par2_byte;
   logic        byte_valid, sop, eop;
   logic [11:0] tail_bits;
   logic        blk_done, blk_len, frame_err;
   logic [7:0]  err_cnt;

   turbo_deframer dut (
      .clk(clk), .rst(rst), .look_now(look_now), .length_in(length_in),
      .xk(xk), .zk(zk), .zkp(zkp),
      .sys_byte(sys_byte), .par1_byte(par1_byte), .par2_byte(par2_byte),
      .byte_valid(byte_valid), .sop(sop), .eop(eop),
      .tail_bits(tail_bits), .blk_done(blk_done), .blk_len(blk_len),
      .frame_err(frame_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] s, p1, p2;
      logic       sop, eop;
   } byte_t;

   typedef struct {
      logic [11:0] t;
      logic        l;
   } blk_t;

   byte_t      bq[$];
   blk_t       kq[$];
   logic [7:0] eq[$];

   int vectors     = 0;
   int miscompares = 0;
   int err_model   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT strobes.
   always @(negedge clk) begin
      if (!rst) begin
         if (byte_valid) begin
            if (bq.size() == 0) begin
               chk("unexpected_byte_valid", 1, 0);
            end else begin
               byte_t b;
               b = bq.pop_front();
               chk("sys_byte", sys_byte, b.s);
               chk("par1_byte", par1_byte, b.p1);
               chk("par2_byte", par2_byte, b.p2);
               chk("sop", sop, b.sop);
               chk("eop", eop, b.eop);
            end
         end else if (sop || eop) begin
            chk("sop_eop_without_byte_valid", {sop, eop}, 0);
         end
         if (blk_done) begin
            if (kq.size() == 0) begin
               chk("unexpected_blk_done", 1, 0);
            end else begin
               blk_t k;
               k = kq.pop_front();
               chk("tail_bits", tail_bits, k.t);
               chk("blk_len", blk_len, k.l);
            end
         end
         if (frame_err) begin
            if (eq.size() == 0) begin
               chk("unexpected_frame_err", 1, 0);
            end else begin
               logic [7:0] e;
               e = eq.pop_front();
               chk("err_cnt_at_frame_err", err_cnt, e);
            end
         end
      end
   end

   // Drives one block (or a truncated one) starting at posedge+1.
   // Leaves look_now high after a complete block so blocks can chain.
   task automatic send_block(input logic len, input logic [7:0] px, input logic [7:0] pz,
                             input logic [7:0] pp, input int ndata, input int ntail,
                             input logic [11:0] tail, input bit tog);
      int k;
      k = len ? 6144 : 1056;
      for (int i = 0; i < ndata; i++) begin
         look_now  = 1'b1;
         length_in = (i == 0) ? len : (tog ? ~length_in : len);
         xk  = px[7 - (i % 8)];
         zk  = pz[7 - (i % 8)];
         zkp = pp[7 - (i % 8)];
         if (i % 8 == 7) begin
            bq.push_back('{s: px, p1: pz, p2: pp, sop: (i == 7), eop: (i == k - 1)});
         end
         @(posedge clk); #1;
      end
      for (int t = 0; t < ntail; t++) begin
         look_now = 1'b1;
         {xk, zk, zkp} = tail[11 - 3*t -: 3];
         @(posedge clk); #1;
      end
      if (ndata == k && ntail == 4) begin
         kq.push_back('{t: tail, l: len});
      end else begin
         if (err_model < 255) err_model++;
         eq.push_back(8'(err_model));
         look_now = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      look_now = 1'b0;
      xk = 1'b0; zk = 1'b0; zkp = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1; look_now = 1'b0; length_in = 1'b0; xk = 1'b0; zk = 1'b0; zkp = 1'b0;
      // Reset held 3 cycles with stimulus toggling.
      for (int i = 0; i < 3; i++) begin
         look_now = ~look_now; xk = ~xk; length_in = ~length_in;
         @(posedge clk); #1;
         chk("reset_outputs",
             {sys_byte, par1_byte, par2_byte, byte_valid, sop, eop, tail_bits,
              blk_done, blk_len, frame_err, err_cnt}, 64'd0);
      end
      look_now = 1'b0;
      rst = 1'b0;
      idle(2);

      // Short block, tail 101,010,111,000 = 12'hAB8.
      send_block(1'b0, 8'hA5, 8'h00, 8'hFF, 1056, 4, 12'hAB8, 1'b0);
      idle(3);

      // Long block back-to-back with a short block.
      send_block(1'b1, 8'h3C, 8'h96, 8'h0F, 6144, 4, 12'h5C3, 1'b0);
      send_block(1'b0, 8'hA5, 8'h00, 8'hFF, 1056, 4, 12'h924, 1'b0);
      idle(3);
      chk("no_frame_err_after_clean_blocks", err_cnt, 8'd0);

      // Long block with length_in toggling after bit 0.
      send_block(1'b1, 8'h81, 8'h7E, 8'hC3, 6144, 4, 12'hFFF, 1'b1);
      idle(3);

      // Drop after 100 data bits, then a clean short block.
      send_block(1'b0, 8'hA5, 8'h00, 8'hFF, 100, 0, 12'h000, 1'b0);
      idle(2);
      chk("err_cnt_after_data_drop", err_cnt, 8'd1);
      send_block(1'b0, 8'hA5, 8'h00, 8'hFF, 1056, 4, 12'hAB8, 1'b0);
      idle(3);

      // Drop after tail cycle 2.
      send_block(1'b0, 8'h5A, 8'hF0, 8'h33, 1056, 3, 12'h123, 1'b0);
      idle(2);
      chk("err_cnt_after_tail_drop", err_cnt, 8'd2);

      // 300 forced errors saturate err_cnt.
      for (int n = 0; n < 300; n++) begin
         send_block(1'b0, 8'hFF, 8'hFF, 8'hFF, 1, 0, 12'h000, 1'b0);
      end
      idle(3);
      chk("err_cnt_saturated", err_cnt, 8'd255);

      idle(20);
      chk("byte_queue_drained", bq.size(), 0);
      chk("blk_queue_drained", kq.size(), 0);
      chk("err_queue_drained", eq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
